// File: rtl/mlp_param_loader_if.sv
// ---------------------------------------------------------------------------
// mlp_param_loader_if
//   Byte-stream handshake between a host/SPI byte source and the MLP
//   parameter loader.
//
//   Signals:
//     load_start  source -> loader  single-cycle pulse that begins a load
//     byte_data   source -> loader  8-bit stream data
//     byte_valid  source -> loader  byte_data is valid
//     byte_ready  loader -> source  loader accepts a byte this cycle
//
//   Modports:
//     master  byte source side
//     slave   loader side
// ---------------------------------------------------------------------------
interface mlp_param_loader_if;
    logic       load_start;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output load_start,
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  load_start,
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/mlp_param_loader.sv
// ---------------------------------------------------------------------------
// mlp_param_loader
//   Writer side of the two-layer MLP parameter store. Accepts a byte stream
//   over a valid/ready handshake and fills the registered layer-1 and layer-2
//   weight and bias arrays in the order W1, B1, W2, B2 (row-major, inner
//   index fastest). Bytes are stored verbatim; the datapath defines their
//   number format.
//
//   Ports:
//     clk_i           clock, all logic on rising edge
//     rst_i           synchronous active-high reset
//     stream_if       slave side of the byte handshake (load_start,
//                     byte_data, byte_valid in; byte_ready out, registered)
//     w1_o            layer-1 weights  [D_IN][D_HID] x 8 bit
//     b1_o            layer-1 biases   [D_HID] x 8 bit
//     w2_o            layer-2 weights  [D_HID][D_OUT] x 8 bit
//     b2_o            layer-2 biases   [D_OUT] x 8 bit
//     params_valid_o  a complete parameter set is held
//     count_o         bytes accepted in the current/last load
// ---------------------------------------------------------------------------
module mlp_param_loader #(
    parameter  int D_IN    = 6,
    parameter  int D_HID   = 16,
    parameter  int D_OUT   = 3,
    localparam int TOTAL   = D_IN*D_HID + D_HID + D_HID*D_OUT + D_OUT,
    localparam int COUNT_W = $clog2(TOTAL + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    mlp_param_loader_if.slave                  stream_if,
    output logic [D_IN-1:0][D_HID-1:0][7:0]    w1_o,
    output logic [D_HID-1:0][7:0]              b1_o,
    output logic [D_HID-1:0][D_OUT-1:0][7:0]   w2_o,
    output logic [D_OUT-1:0][7:0]              b2_o,
    output logic                               params_valid_o,
    output logic [COUNT_W-1:0]                 count_o
);

    // Row/column counters must cover the largest dimension of any section.
    localparam int MAX_DIM = (D_IN > D_HID) ? ((D_IN > D_OUT) ? D_IN : D_OUT)
                                            : ((D_HID > D_OUT) ? D_HID : D_OUT);
    localparam int IDX_W   = $clog2(MAX_DIM + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_W1 = 3'd1,
        LD_B1 = 3'd2,
        LD_W2 = 3'd3,
        LD_B2 = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     row_q, row_d;
    logic [IDX_W-1:0]     col_q, col_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 pvalid_q, pvalid_d;
    logic                 ready_q, ready_d;

    logic [D_IN-1:0][D_HID-1:0][7:0]  w1_q;
    logic [D_HID-1:0][7:0]            b1_q;
    logic [D_HID-1:0][D_OUT-1:0][7:0] w2_q;
    logic [D_OUT-1:0][7:0]            b2_q;

    logic   accept;
    logic   last_col;
    logic   last_row;
    int     rows_lim;
    int     cols_lim;
    state_t next_sec;

    // -----------------------------------------------------------------------
    // Next-state / counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        count_d  = count_q;
        pvalid_d = pvalid_q;
        rows_lim = 1;
        cols_lim = 1;
        next_sec = IDLE;

        // Geometry of the section currently being filled.
        unique case (state_q)
            LD_W1: begin rows_lim = D_IN;  cols_lim = D_HID; next_sec = LD_B1; end
            LD_B1: begin rows_lim = 1;     cols_lim = D_HID; next_sec = LD_W2; end
            LD_W2: begin rows_lim = D_HID; cols_lim = D_OUT; next_sec = LD_B2; end
            LD_B2: begin rows_lim = 1;     cols_lim = D_OUT; next_sec = IDLE;  end
            default: begin rows_lim = 1;   cols_lim = 1;     next_sec = IDLE;  end
        endcase

        // ready_q is high only in LD_* states, so no byte is taken in IDLE.
        accept   = stream_if.byte_valid && ready_q;
        last_col = (col_q == IDX_W'(cols_lim - 1));
        last_row = (row_q == IDX_W'(rows_lim - 1));

        if (state_q == IDLE) begin
            if (stream_if.load_start) begin
                state_d  = LD_W1;
                row_d    = '0;
                col_d    = '0;
                count_d  = '0;
                pvalid_d = 1'b0;
            end
        end else if (accept) begin
            count_d = count_q + COUNT_W'(1);
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    state_d = next_sec;
                    // Last byte of the whole set: valid rises together with
                    // the final entry becoming visible.
                    if (state_q == LD_B2) begin
                        pvalid_d = 1'b1;
                    end
                end else begin
                    row_d = row_q + IDX_W'(1);
                end
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end

        ready_d = (state_d != IDLE);
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            count_q  <= '0;
            pvalid_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            count_q  <= count_d;
            pvalid_q <= pvalid_d;
            ready_q  <= ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // Parameter storage: the accepted byte lands at [row_q][col_q] of the
    // section selected by the current state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w1_q <= '0;
            b1_q <= '0;
            w2_q <= '0;
            b2_q <= '0;
        end else if (accept) begin
            unique case (state_q)
                LD_W1: begin
                    for (int i = 0; i < D_IN; i++) begin
                        for (int j = 0; j < D_HID; j++) begin
                            if (row_q == IDX_W'(i) && col_q == IDX_W'(j)) begin
                                w1_q[i][j] <= stream_if.byte_data;
                            end
                        end
                    end
                end
                LD_B1: begin
                    for (int j = 0; j < D_HID; j++) begin
                        if (col_q == IDX_W'(j)) begin
                            b1_q[j] <= stream_if.byte_data;
                        end
                    end
                end
                LD_W2: begin
                    for (int h = 0; h < D_HID; h++) begin
                        for (int k = 0; k < D_OUT; k++) begin
                            if (row_q == IDX_W'(h) && col_q == IDX_W'(k)) begin
                                w2_q[h][k] <= stream_if.byte_data;
                            end
                        end
                    end
                end
                LD_B2: begin
                    for (int k = 0; k < D_OUT; k++) begin
                        if (col_q == IDX_W'(k)) begin
                            b2_q[k] <= stream_if.byte_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stream_if.byte_ready = ready_q;
    assign w1_o                 = w1_q;
    assign b1_o                 = b1_q;
    assign w2_o                 = w2_q;
    assign b2_o                 = b2_q;
    assign params_valid_o       = pvalid_q;
    assign count_o              = count_q;

endmodule
